text_overlay: RTL and testbench



---
 rtl/text_overlay_pkg.sv | 34 +++
 rtl/text_overlay_if.sv | 13 +
 rtl/text_overlay_bcd_counter.sv | 53 +++++
 rtl/text_overlay.sv | 215 +++++++++++++++++++++
 tb/tb_text_overlay.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/text_overlay_pkg.sv
// Shared definitions for the text overlay: game state encodings, font-ROM bus
// widths, character and colour constants, and the fixed label strings.
// A label string is packed with its first (leftmost) character in the MSB byte.
package text_overlay_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_READY = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } game_state_e;

  localparam int unsigned ROM_AW = 11;
  localparam int unsigned ROM_DW = 8;

  localparam logic [6:0] CH_BLANK  = 7'h00;
  localparam logic [6:0] CH_DIGIT0 = 7'h30;

  localparam logic [11:0] COL_SCORE = 12'hF00;
  localparam logic [11:0] COL_MSG   = 12'hFFF;

  localparam logic [47:0] STR_SCORE = "SCORE:";
  localparam logic [39:0] STR_BALL  = "BALL:";
  localparam logic [39:0] STR_READY = "READY";
  localparam logic [71:0] STR_OVER  = "GAME OVER";

  // Character idx (0 = leftmost) of a len-character string, zero-extended to
  // 72 bits. Only the 7-bit ASCII part of each byte is returned.
  function automatic logic [6:0] str_char(input logic [71:0] str, input int unsigned len,
                                          input int unsigned idx);
    return str[8 * (len - 1 - idx) +: 7];
  endfunction

endpackage

// File: rtl/text_overlay_if.sv
// Font ROM read bus.
//   rom_addr : {char[6:0], row[3:0]} driven by the overlay
//   rom_data : glyph row returned by the ROM one clock after rom_addr
// master = overlay side, slave = ROM side.
interface text_overlay_if;
  import text_overlay_pkg::*;

  logic [ROM_AW-1:0] rom_addr;
  logic [ROM_DW-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/text_overlay_bcd_counter.sv
// Cascaded BCD up-counter that saturates at all nines.
//   clk, reset : pixel clock, asynchronous active-high reset
//   inc_i      : add one (ignored when saturated)
//   clr_i      : clear to zero; wins over inc_i
//   value_o    : BCD value, digit 0 in the LSBs
//   max_o      : value is all nines
module bcd_counter #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc_i,
  input  logic                  clr_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic                  max_o
);

  logic [4*DIGITS-1:0] value_q, value_d;
  logic                all_nines;
  logic                carry;

  always_comb begin
    all_nines = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (value_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
    end
  end

  always_comb begin
    value_d = value_q;
    carry   = inc_i & ~all_nines;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value_q[4*i +: 4] == 4'd9) begin
          value_d[4*i +: 4] = 4'd0;
        end else begin
          value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
    if (clr_i) value_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value_o = value_q;
  assign max_o   = all_nines;

endmodule

// File: rtl/text_overlay.sv
// Score / message text overlay for the pong display.
// Looks up the character under the current pixel, drives the font ROM address
// in the same cycle, and registers text_on / text_rgb from the returned glyph
// row one cycle later (2 clk from x/y to text_rgb).
//   clk, reset       : pixel clock, asynchronous active-high reset
//   x_i, y_i         : current pixel column / row
//   frame_tick_i     : one pulse per frame, drives the GAME OVER blink
//   state_i          : game state (PLAY / READY / PAUSE / OVER)
//   ball_i           : balls remaining
//   score_inc_i/clr_i: score counter controls
//   rom              : font ROM bus (master side)
//   text_rgb_o       : overlay colour, 0 when text_on_o is low
//   text_on_o        : overlay pixel active
//   score_o          : BCD score, digit 0 in the LSBs
//   score_max_o      : score saturated at all nines
module text_overlay
  import text_overlay_pkg::*;
#(
  parameter int unsigned DIGITS       = 2,
  parameter int unsigned SCALE        = 1,
  parameter int unsigned SCORE_X      = 240,
  parameter int unsigned SCORE_Y      = 40,
  parameter int unsigned MSG_X        = 248,
  parameter int unsigned MSG_Y        = 224,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned LZ_BLANK     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           x_i,
  input  logic [9:0]           y_i,
  input  logic                 frame_tick_i,
  input  logic [1:0]           state_i,
  input  logic [1:0]           ball_i,
  input  logic                 score_inc_i,
  input  logic                 score_clr_i,
  text_overlay_if.master       rom,
  output logic [11:0]          text_rgb_o,
  output logic                 text_on_o,
  output logic [4*DIGITS-1:0]  score_o,
  output logic                 score_max_o
);

  localparam int unsigned SCORE_LEN = 13 + DIGITS;
  localparam int unsigned CW_SH     = 3 + SCALE;
  localparam int unsigned BW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // ---------------------------------------------------------------- score
  logic [4*DIGITS-1:0] score_w;

  bcd_counter #(
    .DIGITS (DIGITS)
  ) u_bcd_counter (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (score_inc_i),
    .clr_i   (score_clr_i),
    .value_o (score_w),
    .max_o   (score_max_o)
  );

  assign score_o = score_w;

  // ---------------------------------------------------------------- blink
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blank_q, blank_d;  // 1 = GAME OVER hidden

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blank_d     = blank_q;
    if (state_i != ST_OVER) begin
      // Every entry into OVER starts a fresh visible half-period.
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (frame_tick_i) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_d = '0;
        blank_d     = ~blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- geometry
  // 11-bit offsets keep the sign: bit 10 set means the pixel is left of / above
  // the region origin.
  logic [10:0] sdx, sdy, mdx, mdy;
  logic [10:0] s_idx, m_idx;
  int unsigned si, mi;

  assign sdx   = {1'b0, x_i} - 11'(SCORE_X);
  assign sdy   = {1'b0, y_i} - 11'(SCORE_Y);
  assign mdx   = {1'b0, x_i} - 11'(MSG_X);
  assign mdy   = {1'b0, y_i} - 11'(MSG_Y);
  assign s_idx = sdx >> CW_SH;
  assign m_idx = mdx >> CW_SH;
  assign si    = 32'(s_idx);
  assign mi    = 32'(m_idx);

  // ---------------------------------------------------------------- digits
  logic [6:0] dig_char [DIGITS];

  always_comb begin : digit_chars
    logic zero_run;
    dig_char = '{default: CH_BLANK};
    zero_run = 1'b1;
    // Walk from the most-significant digit; blank zeros until the first
    // non-zero digit, but always show digit 0.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (score_w[4*k +: 4] == 4'd0);
      if ((LZ_BLANK != 0) && zero_run && (k != 0)) dig_char[k] = CH_BLANK;
      else dig_char[k] = CH_DIGIT0 + {3'b000, score_w[4*k +: 4]};
    end
  end

  // ---------------------------------------------------------------- characters
  logic [6:0] s_char, m_char;
  logic       s_in, m_in;

  always_comb begin
    s_char = CH_BLANK;
    if (si < 6) begin
      s_char = str_char({24'd0, STR_SCORE}, 6, si);
    end else if (si < 6 + DIGITS) begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
        if (si == 6 + DIGITS - 1 - k) s_char = dig_char[k];
      end
    end else if ((si >= 7 + DIGITS) && (si < 12 + DIGITS)) begin
      s_char = str_char({32'd0, STR_BALL}, 5, si - (7 + DIGITS));
    end else if (si == 12 + DIGITS) begin
      s_char = CH_DIGIT0 + {5'b00000, ball_i};
    end
  end

  always_comb begin
    m_char = CH_BLANK;
    if (state_i == ST_OVER) begin
      if (mi < 9) m_char = str_char(STR_OVER, 9, mi);
    end else begin
      if (mi < 5) m_char = str_char({32'd0, STR_READY}, 5, mi);
    end
  end

  always_comb begin
    s_in = !sdx[10] && !sdy[10] && (si < SCORE_LEN) && ((sdy >> SCALE) < 11'd16) &&
           (state_i != ST_READY);
    m_in = !mdx[10] && !mdy[10] && ((mdy >> SCALE) < 11'd16) &&
           (((state_i == ST_READY) && (mi < 5)) ||
            ((state_i == ST_OVER) && (mi < 9) && !blank_q));
  end

  // ---------------------------------------------------------------- stage 0
  logic       hit_d, hit_q;
  logic       msg_d, msg_q;
  logic [2:0] col_d, col_q;
  logic [6:0] char_sel;
  logic [3:0] row_sel;

  always_comb begin
    hit_d    = 1'b0;
    msg_d    = 1'b0;
    col_d    = 3'd0;
    char_sel = CH_BLANK;
    row_sel  = 4'd0;
    // Message beats score where the two regions overlap.
    if (m_in) begin
      hit_d    = 1'b1;
      msg_d    = 1'b1;
      char_sel = m_char;
      row_sel  = 4'(mdy >> SCALE);
      col_d    = 3'(mdx >> SCALE);
    end else if (s_in) begin
      hit_d    = 1'b1;
      char_sel = s_char;
      row_sel  = 4'(sdy >> SCALE);
      col_d    = 3'(sdx >> SCALE);
    end
  end

  assign rom.rom_addr = {char_sel, row_sel};

  // ---------------------------------------------------------------- stage 1
  logic        text_on_d, text_on_q;
  logic [11:0] text_rgb_d, text_rgb_q;

  always_comb begin
    text_on_d  = hit_q & rom.rom_data[3'd7 - col_q];
    text_rgb_d = text_on_d ? (msg_q ? COL_MSG : COL_SCORE) : 12'h000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
      hit_q       <= 1'b0;
      msg_q       <= 1'b0;
      col_q       <= 3'd0;
      text_on_q   <= 1'b0;
      text_rgb_q  <= 12'h000;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
      hit_q       <= hit_d;
      msg_q       <= msg_d;
      col_q       <= col_d;
      text_on_q   <= text_on_d;
      text_rgb_q  <= text_rgb_d;
    end
  end

  assign text_on_o  = text_on_q;
  assign text_rgb_o = text_rgb_q;

endmodule

// File: tb/tb_text_overlay.sv
module tb_text_overlay;
  import text_overlay_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic        frame_tick;
  logic [1:0]  state, ball;
  logic        score_inc, score_clr;
  logic [11:0] text_rgb;
  logic        text_on;
  logic [7:0]  score;
  logic        score_max;
  logic [7:0]  rom_q = 8'h00;

  always #5 clk = ~clk;

  text_overlay_if rom_bus ();

  text_overlay dut (
    .clk          (clk),
    .reset        (reset),
    .x_i          (x),
    .y_i          (y),
    .frame_tick_i (frame_tick),
    .state_i      (state),
    .ball_i       (ball),
    .score_inc_i  (score_inc),
    .score_clr_i  (score_clr),
    .rom          (rom_bus),
    .text_rgb_o   (text_rgb),
    .text_on_o    (text_on),
    .score_o      (score),
    .score_max_o  (score_max)
  );

  // Synthetic font: char 0 is empty, any other glyph has its leftmost pixel lit
  // and the remaining bits depend on char and row.
  function automatic logic [7:0] font(input logic [6:0] c, input logic [3:0] r);
    if (c == 7'h00) return 8'h00;
    return {1'b1, c ^ {3'b000, r}};
  endfunction

  always @(posedge clk) rom_q <= font(rom_bus.rom_addr[10:4], rom_bus.rom_addr[3:0]);
  assign rom_bus.rom_data = rom_q;

  // ---------------------------------------------------------------- scoreboard
  // kind 0: rom_addr, 1: {text_on, text_rgb}, 2: {score_max, score}
  typedef struct {
    int          kind;
    logic [15:0] val;
    string       name;
  } chk_t;

  chk_t q_now[$];   // checked in the cycle the probe is driven
  chk_t q_pix[$];   // checked two clocks after the probe
  logic now_f = 1'b0, pix_f = 1'b0, final_f = 1'b0;
  logic pd1 = 1'b0, pd2 = 1'b0;
  int   total = 0, bad = 0;

  always @(posedge clk) begin
    pd1 <= pix_f;
    pd2 <= pd1;
  end

  task automatic compare(input chk_t c);
    logic [15:0] act;
    case (c.kind)
      0:       act = {5'b0, rom_bus.rom_addr};
      1:       act = {3'b0, text_on, text_rgb};
      default: act = {7'b0, score_max, score};
    endcase
    total++;
    if (act !== c.val) begin
      bad++;
      $display("FAIL %s: got %h expected %h", c.name, act, c.val);
    end
  endtask

  always @(negedge clk) begin
    if (now_f) begin
      if (q_now.size() == 0) begin
        total++; bad++;
        $display("FAIL now_queue: got empty expected entry");
      end else compare(q_now.pop_front());
    end
    if (pd2) begin
      if (q_pix.size() == 0) begin
        total++; bad++;
        $display("FAIL pix_queue: got empty expected entry");
      end else compare(q_pix.pop_front());
    end
    if (final_f) begin
      total++;
      if (q_now.size() + q_pix.size() != 0) begin
        bad++;
        $display("FAIL drain: got %0d pending expected 0", q_now.size() + q_pix.size());
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_now(input int kind, input logic [15:0] val, input string nm);
    chk_t c;
    c.kind = kind; c.val = val; c.name = nm;
    q_now.push_back(c);
    now_f = 1'b1;
  endtask

  task automatic probe(input int px, input int py, input logic [6:0] c, input logic [3:0] row,
                       input logic [2:0] col, input logic [11:0] color, input bit chk_addr,
                       input string nm);
    chk_t       e;
    logic [7:0] f;
    logic       on;
    x = 10'(px);
    y = 10'(py);
    f  = font(c, row);
    on = f[3'd7 - col];
    if (chk_addr) push_now(0, {5'b0, c, row}, {nm, "_addr"});
    e.kind = 1; e.val = {3'b0, on, on ? color : 12'h000}; e.name = {nm, "_pix"};
    q_pix.push_back(e);
    pix_f = 1'b1;
    cyc();
    pix_f = 1'b0;
    now_f = 1'b0;
  endtask

  task automatic check_score(input logic [7:0] v, input logic m, input string nm);
    push_now(2, {7'b0, m, v}, nm);
    cyc();
    now_f = 1'b0;
  endtask

  task automatic pulse_inc(input int n);
    repeat (n) begin
      score_inc = 1'b1;
      cyc();
      score_inc = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  initial begin
    reset = 1'b1; x = '0; y = '0; frame_tick = 1'b0; state = ST_PLAY; ball = 2'd3;
    score_inc = 1'b0; score_clr = 1'b0;
    cyc(); cyc();
    push_now(1, 16'h0000, "reset_pix");
    cyc(); now_f = 1'b0;
    check_score(8'h00, 1'b0, "reset_score");
    reset = 1'b0;
    cyc(); cyc();

    // Score line in PLAY, score 0, ball 3
    probe(240, 40, 7'h53, 4'd0, 3'd0, COL_SCORE, 1, "S_origin");
    probe(242, 40, 7'h53, 4'd0, 3'd1, COL_SCORE, 1, "S_col1");
    probe(244, 40, 7'h53, 4'd0, 3'd2, COL_SCORE, 1, "S_col2");
    probe(240, 42, 7'h53, 4'd1, 3'd0, COL_SCORE, 1, "S_row1");
    probe(336, 40, 7'h00, 4'd0, 3'd0, COL_SCORE, 1, "lz_digit1");
    probe(352, 40, 7'h30, 4'd0, 3'd0, COL_SCORE, 1, "digit0_zero");
    probe(368, 40, 7'h00, 4'd0, 3'd0, COL_SCORE, 1, "gap_blank");
    probe(384, 40, 7'h42, 4'd0, 3'd0, COL_SCORE, 1, "B_of_ball");
    probe(464, 40, 7'h33, 4'd0, 3'd0, COL_SCORE, 1, "ball_digit");
    probe(480, 40, 7'h00, 4'd0, 3'd0, COL_SCORE, 0, "past_end");
    probe(239, 40, 7'h00, 4'd0, 3'd0, COL_SCORE, 0, "left_of_x0");
    probe(240, 39, 7'h00, 4'd0, 3'd0, COL_SCORE, 0, "above_y0");
    probe(240, 72, 7'h00, 4'd0, 3'd0, COL_SCORE, 0, "below_cell");

    // Score counter
    pulse_inc(7);
    check_score(8'h07, 1'b0, "score7");
    probe(336, 40, 7'h00, 4'd0, 3'd0, COL_SCORE, 1, "score7_d1");
    probe(352, 40, 7'h37, 4'd0, 3'd0, COL_SCORE, 1, "score7_d0");
    pulse_inc(3);
    check_score(8'h10, 1'b0, "score10");
    probe(336, 40, 7'h31, 4'd0, 3'd0, COL_SCORE, 1, "score10_d1");
    pulse_inc(89);
    check_score(8'h99, 1'b1, "score99");
    pulse_inc(1);
    check_score(8'h99, 1'b1, "score_sat");
    probe(336, 40, 7'h39, 4'd0, 3'd0, COL_SCORE, 1, "score99_d1");
    score_clr = 1'b1; score_inc = 1'b1;
    cyc();
    score_clr = 1'b0; score_inc = 1'b0;
    check_score(8'h00, 1'b0, "clr_beats_inc");

    // READY message
    state = ST_READY;
    probe(248, 224, 7'h52, 4'd0, 3'd0, COL_MSG, 1, "ready_R");
    probe(247, 224, 7'h00, 4'd0, 3'd0, COL_MSG, 0, "ready_left");
    probe(312, 224, 7'h59, 4'd0, 3'd0, COL_MSG, 1, "ready_Y");
    probe(328, 224, 7'h00, 4'd0, 3'd0, COL_MSG, 0, "ready_end");
    probe(248, 255, 7'h52, 4'd15, 3'd0, COL_MSG, 1, "ready_row15");
    probe(240, 40, 7'h00, 4'd0, 3'd0, COL_SCORE, 0, "ready_no_score");

    // GAME OVER blink
    state = ST_OVER;
    cyc();
    probe(248, 224, 7'h47, 4'd0, 3'd0, COL_MSG, 1, "over_G");
    probe(376, 224, 7'h52, 4'd0, 3'd0, COL_MSG, 1, "over_R");
    probe(240, 40, 7'h53, 4'd0, 3'd0, COL_SCORE, 1, "over_score");
    ticks(29);
    probe(248, 224, 7'h47, 4'd0, 3'd0, COL_MSG, 1, "blink29_vis");
    ticks(1);
    probe(248, 224, 7'h00, 4'd0, 3'd0, COL_MSG, 0, "blink30_blank");
    ticks(29);
    probe(248, 224, 7'h00, 4'd0, 3'd0, COL_MSG, 0, "blink59_blank");
    ticks(1);
    probe(248, 224, 7'h47, 4'd0, 3'd0, COL_MSG, 1, "blink60_vis");
    ticks(30);
    probe(248, 224, 7'h00, 4'd0, 3'd0, COL_MSG, 0, "blink90_blank");
    state = ST_PLAY;
    cyc();
    state = ST_OVER;
    probe(248, 224, 7'h47, 4'd0, 3'd0, COL_MSG, 1, "reenter_vis");

    // Reset mid-scan
    state = ST_PLAY;
    probe(240, 40, 7'h53, 4'd0, 3'd0, COL_SCORE, 1, "pre_reset");
    cyc(); cyc(); cyc();
    reset = 1'b1;
    push_now(1, 16'h0000, "reset_async");
    cyc(); now_f = 1'b0;
    cyc();
    reset = 1'b0;
    push_now(1, 16'h0000, "release_c0");
    cyc(); now_f = 1'b0;
    push_now(1, 16'h0000, "release_c1");
    cyc(); now_f = 1'b0;
    push_now(1, {4'h1, COL_SCORE}, "release_c2");
    cyc(); now_f = 1'b0;

    repeat (4) cyc();
    final_f = 1'b1;
    cyc();
    final_f = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
